axi_mem_responder: RTL
======================

# axi_mem_responder

AXI4 slave memory model that answers the burst read and write traffic issued by the kernel's AXI4 read/write masters: it accepts read bursts and returns data beats, and accepts write bursts and returns a write response. It sits on the far side of the `m00_axi` port, in place of device memory, for kernel-level simulation and on-chip loopback tests. Storage is an internal line-wide array that the bench can preload and inspect through a debug port.

## Interface
- C_ADDR_WIDTH, 64, AXI byte address width
- C_DATA_WIDTH, 512, data bus width; one memory line per beat
- C_DEPTH_LOG2, 10, log2 of memory depth in lines
- aclk  in  1  single clock for all logic
- areset  in  1  reset, synchronous and active-high
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake
- s_axi_awaddr  in  C_ADDR_WIDTH  burst start byte address
- s_axi_awlen  in  8  beats minus one
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake
- s_axi_wdata  in  C_DATA_WIDTH  write beat
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat marker from master
- s_axi_bvalid / s_axi_bready  out/in  1  write response handshake (always OKAY, no bresp port)
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake
- s_axi_araddr  in  C_ADDR_WIDTH  burst start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_rvalid / s_axi_rready  out/in  1  read-data handshake
- s_axi_rdata  out  C_DATA_WIDTH  read beat
- s_axi_rlast  out  1  last read beat
- dbg_we  in  1  debug line write (preload)
- dbg_addr  in  C_DEPTH_LOG2  debug line index
- dbg_wdata  in  C_DATA_WIDTH  debug write data
- dbg_rdata  out  C_DATA_WIDTH  registered debug read of mem[dbg_addr]
- err_wlast  out  1  sticky: wlast disagreed with beat count
- wr_beats / rd_beats  out  32  accepted beat counters, wrap at 2^32

## Operation
- Line index = addr[LSB+C_DEPTH_LOG2-1:LSB], LSB = log2(C_DATA_WIDTH/8). Low address bits and upper bits are ignored; the index increments by 1 per beat and wraps modulo 2^C_DEPTH_LOG2. Burst type is INCR only.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. An AW handshake latches the index and sets the beat counter to awlen.
  - W_DATA: wready=1. Each W handshake writes the bytes of wdata enabled by wstrb, increments the index and decrements the counter. On the beat with counter==0, go to W_RESP.
  - err_wlast is set when wlast != (counter==0) on any accepted beat. Completion always follows the counter, not wlast.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. An AR handshake registers rdata<=mem[index], sets the counter to arlen, and enters R_DATA.
  - R_DATA: rvalid=1; rlast=(counter==0). On an R handshake with counter!=0, rdata<=mem[index+1] in the same cycle, so beats stream back-to-back. With counter==0, go to R_IDLE.
  - rvalid/rdata/rlast hold stable while rready=0.
- The read and write FSMs are independent and may be active concurrently. Collision (write and read-load of the same line in the same cycle) is read-first: the read returns the old data.
- A dbg_we write in the same cycle as an AXI write to the same line: the AXI write wins.
- wr_beats/rd_beats increment on each W/R handshake.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0, err_wlast=0, counters=0, both FSMs in IDLE. awready and arready go to 1 the cycle after areset deasserts.
- Memory contents are not cleared by reset. A reset mid-burst aborts the burst; beats already written stay written.
- AW handshake to first wready=1: 1 cycle. Last W beat to bvalid: 1 cycle.
- AR handshake to rvalid=1: 1 cycle. Throughput is 1 beat/cycle in both directions when the master does not stall.
- awready=0 outside W_IDLE; arready=0 outside R_IDLE. There is one outstanding burst per direction.
- dbg_rdata: 1-cycle registered read.

## Test plan
- Preload lines 0..3 via dbg, then AR addr=0x0, arlen=3 with rready=1 -> rvalid high for 4 consecutive cycles starting 1 cycle after AR, data = lines 0..3, rlast on beat 4 only, rd_beats=4.
- AW addr=0x40, awlen=1, two beats with wstrb all-ones then 0x0000_0000_0000_00FF -> line 1 fully written, line 2 changes only bytes 0..7, one bvalid, wr_beats=2.
- Read of 4 beats with rready toggling 1,0,0,1,… -> rdata and rlast stable while stalled, no beats lost or duplicated.
- AR at index 2^C_DEPTH_LOG2-1, arlen=1 -> second beat returns line 0 (wrap).
- Write burst awlen=2 with wlast asserted on beat 2 -> err_wlast=1 and stays 1, the third beat is still accepted, bvalid after beat 3.
- areset pulsed during R_DATA beat 2 of 8 -> next cycle rvalid=0 and arready=0, then arready=1; a new AR is served normally and preloaded memory is intact.

Source files
------------

// File: rtl/axi_mem_responder_if.sv
// AXI4 burst read/write channel bundle between a kernel master and the memory responder.
// No ID, size, burst-type or response fields: bursts are INCR only and always answer OKAY.
interface axi_mem_responder_if #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 512
);
    logic                      awvalid;
    logic                      awready;
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                awlen;
    logic                      wvalid;
    logic                      wready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wlast;
    logic                      bvalid;
    logic                      bready;
    logic                      arvalid;
    logic                      arready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                arlen;
    logic                      rvalid;
    logic                      rready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic                      rlast;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: independent INCR burst read and write engines over a line-wide
// array, one line per beat, plus a debug port for preloading and inspecting the contents.
module axi_mem_responder #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 512,
    parameter int unsigned C_DEPTH_LOG2 = 10
) (
    input  logic                    aclk,
    input  logic                    areset,
    axi_mem_responder_if.slave      s_axi,
    input  logic                    dbg_we,
    input  logic [C_DEPTH_LOG2-1:0] dbg_addr,
    input  logic [C_DATA_WIDTH-1:0] dbg_wdata,
    output logic [C_DATA_WIDTH-1:0] dbg_rdata,
    output logic                    err_wlast,
    output logic [31:0]             wr_beats,
    output logic [31:0]             rd_beats
);
    localparam int unsigned NumBytes = C_DATA_WIDTH / 8;
    localparam int unsigned Lsb      = $clog2(NumBytes);
    localparam int unsigned Depth    = 2 ** C_DEPTH_LOG2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    logic [C_DATA_WIDTH-1:0] mem [Depth];

    logic [1:0]              w_state;
    logic                    r_state;
    logic                    ready_en;
    logic [C_DEPTH_LOG2-1:0] w_idx;
    logic [C_DEPTH_LOG2-1:0] r_idx;
    logic [C_DEPTH_LOG2-1:0] r_next_idx;
    logic [C_DEPTH_LOG2-1:0] aw_idx;
    logic [C_DEPTH_LOG2-1:0] ar_idx;
    logic [7:0]              w_cnt;
    logic [7:0]              r_cnt;
    logic [C_DATA_WIDTH-1:0] rdata;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;

    // ready_en holds both address channels closed for the reset cycle itself.
    assign s_axi.awready = ready_en && (w_state == W_IDLE);
    assign s_axi.wready  = (w_state == W_DATA);
    assign s_axi.bvalid  = (w_state == W_RESP);
    assign s_axi.arready = ready_en && (r_state == R_IDLE);
    assign s_axi.rvalid  = (r_state == R_DATA);
    assign s_axi.rlast   = (r_state == R_DATA) && (r_cnt == 8'd0);
    assign s_axi.rdata   = rdata;

    assign aw_hs      = s_axi.awvalid && s_axi.awready;
    assign w_hs       = s_axi.wvalid && s_axi.wready;
    assign b_hs       = s_axi.bvalid && s_axi.bready;
    assign ar_hs      = s_axi.arvalid && s_axi.arready;
    assign r_hs       = s_axi.rvalid && s_axi.rready;
    assign aw_idx     = s_axi.awaddr[Lsb +: C_DEPTH_LOG2];
    assign ar_idx     = s_axi.araddr[Lsb +: C_DEPTH_LOG2];
    assign r_next_idx = r_idx + 1'b1;

    // Storage is never reset; a debug write loses to an AXI write of the same line.
    always_ff @(posedge aclk) begin
        if (dbg_we && !(w_hs && !areset && (w_idx == dbg_addr))) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (w_hs && !areset) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
        dbg_rdata <= mem[dbg_addr];
    end

    always_ff @(posedge aclk) begin
        ready_en <= !areset;
    end

    // Completion follows the beat counter; a wrong wlast only raises the sticky flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            w_idx     <= '0;
            w_cnt     <= '0;
            err_wlast <= 1'b0;
            wr_beats  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_idx   <= aw_idx;
                        w_cnt   <= s_axi.awlen;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_beats <= wr_beats + 32'd1;
                        w_idx    <= w_idx + 1'b1;
                        w_cnt    <= w_cnt - 8'd1;
                        if (s_axi.wlast != (w_cnt == 8'd0)) err_wlast <= 1'b1;
                        if (w_cnt == 8'd0) w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // The next line is fetched on the accepting edge so beats stream without bubbles;
    // reading mem here sees pre-write contents, giving read-first collisions.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= R_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            rdata    <= '0;
            rd_beats <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_idx   <= ar_idx;
                        r_cnt   <= s_axi.arlen;
                        rdata   <= mem[ar_idx];
                        r_state <= R_DATA;
                    end
                end
                default: begin
                    if (r_hs) begin
                        rd_beats <= rd_beats + 32'd1;
                        if (r_cnt == 8'd0) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_idx <= r_next_idx;
                            r_cnt <= r_cnt - 8'd1;
                            rdata <= mem[r_next_idx];
                        end
                    end
                end
            endcase
        end
    end
endmodule
